pc_fetch_stage: RTL

PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

---
 rtl/pc_fetch_stage_if.sv | 68 ++++++
 rtl/pc_fetch_stage.sv | 120 ++++++++++++
 2 files changed

// File: rtl/pc_fetch_stage_if.sv
// pc_fetch_stage_if -- the signal bundle between the fetch stage and its
// neighbours: the PC adder, instruction memory, the execute-stage redirect
// and the IF/ID slot.
//
// Ports (as seen from the fetch stage, modport master):
//   pcOut        out 32  current fetch PC; also the instruction-memory address
//   pcPlus4      in  32  PC adder result (pcOut + 4)
//   branchTaken  in  1   redirect request from execute
//   branchTarget in  32  redirect address; bits [1:0] are ignored
//   imemReq      out 1   fetch request
//   imemReady    in  1   memory accepts imemReq this cycle
//   imemValid    in  1   imemRdata is valid
//   imemRdata    in  32  fetched instruction word
//   ifidValid    out 1   IF/ID slot holds an instruction
//   ifidPC       out 32  PC of the instruction in the slot
//   ifidInstr    out 32  instruction in the slot (NOP while ifidValid=0)
//   ifidReady    in  1   decode consumes the slot this cycle
//
// Handshake semantics: a transfer happens on a rising edge where the
// producer's valid/request and the consumer's ready are both 1. imemReq with
// imemReady accepts a fetch; imemValid (one or more cycles later) returns its
// data with no back-pressure. ifidValid with ifidReady consumes the slot;
// while ifidValid=1 and ifidReady=0 the slot contents are held stable.
// The modport slave is the environment side of the same signals.
interface pc_fetch_stage_if;
  logic [31:0] pcOut;
  logic [31:0] pcPlus4;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        imemReq;
  logic        imemReady;
  logic        imemValid;
  logic [31:0] imemRdata;
  logic        ifidValid;
  logic [31:0] ifidPC;
  logic [31:0] ifidInstr;
  logic        ifidReady;

  modport master (
    output pcOut,
    input  pcPlus4,
    input  branchTaken,
    input  branchTarget,
    output imemReq,
    input  imemReady,
    input  imemValid,
    input  imemRdata,
    output ifidValid,
    output ifidPC,
    output ifidInstr,
    input  ifidReady
  );

  modport slave (
    input  pcOut,
    output pcPlus4,
    output branchTaken,
    output branchTarget,
    input  imemReq,
    output imemReady,
    output imemValid,
    output imemRdata,
    input  ifidValid,
    input  ifidPC,
    input  ifidInstr,
    output ifidReady
  );
endinterface

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage -- instruction fetch with a single outstanding memory
// request, an IF/ID output slot backed by a 1-entry skid buffer, and
// redirect handling that discards a response already in flight.
//
// Ports:
//   clock      in   single clock, rising edge
//   reset      in   synchronous, active-high
//   bus        pc_fetch_stage_if.master (PC, imem and IF/ID signals)
//   dbg_state  out  current FSM state (0=REQ, 1=WAIT, 2=DRAIN)
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic             clock,
  input  logic             reset,
  pc_fetch_stage_if.master bus,
  output logic [1:0]       dbg_state
);

  // REQ: may issue a fetch. WAIT: fetch outstanding, response wanted.
  // DRAIN: fetch outstanding but a redirect happened, response is dropped.
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic        slot_valid;
  logic [31:0] slot_pc;
  logic [31:0] slot_instr;
  logic        skid_valid;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;

  logic req;
  logic accept;
  logic capture;
  logic slot_free;
  logic slot_drain;

  // Only requesting with an empty skid guarantees the returning word always
  // has somewhere to land. Reset gates the request so nothing is issued
  // while reset is held, even before the first reset edge.
  assign req        = !reset && (state == S_REQ) && !skid_valid;
  assign accept     = req && bus.imemReady;
  assign capture    = (state == S_WAIT) && bus.imemValid && !bus.branchTaken;
  assign slot_drain = slot_valid && bus.ifidReady;
  assign slot_free  = !slot_valid || bus.ifidReady;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_REQ;
      pc_q       <= RESET_PC;
      slot_valid <= 1'b0;
      slot_pc    <= 32'h0;
      slot_instr <= NOP_INSTR;
      skid_valid <= 1'b0;
      skid_pc    <= 32'h0;
      skid_instr <= NOP_INSTR;
    end else if (bus.branchTaken) begin
      // Redirect wins over capture and over decode consuming the slot.
      pc_q       <= {bus.branchTarget[31:2], 2'b00};
      slot_valid <= 1'b0;
      slot_instr <= NOP_INSTR;
      skid_valid <= 1'b0;
      // DRAIN whenever a request is (or is becoming) outstanding and its
      // response has not arrived in this same cycle.
      case (state)
        S_REQ:   state <= accept ? S_DRAIN : S_REQ;
        S_WAIT:  state <= bus.imemValid ? S_REQ : S_DRAIN;
        S_DRAIN: state <= bus.imemValid ? S_REQ : S_DRAIN;
        default: state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ:   if (accept) state <= S_WAIT;
        S_WAIT:  if (bus.imemValid) state <= S_REQ;
        S_DRAIN: if (bus.imemValid) state <= S_REQ;
        default: state <= S_REQ;
      endcase

      if (capture) begin
        pc_q <= {bus.pcPlus4[31:2], 2'b00};
        // Skid is always empty in WAIT, so one of the two targets is free.
        if (slot_free) begin
          slot_valid <= 1'b1;
          slot_pc    <= pc_q;
          slot_instr <= bus.imemRdata;
        end else begin
          skid_valid <= 1'b1;
          skid_pc    <= pc_q;
          skid_instr <= bus.imemRdata;
        end
      end else if (slot_drain) begin
        if (skid_valid) begin
          slot_pc    <= skid_pc;
          slot_instr <= skid_instr;
          skid_valid <= 1'b0;
        end else begin
          slot_valid <= 1'b0;
          slot_instr <= NOP_INSTR;
        end
      end
    end
  end

  // Low address bits are forced to zero, so these inputs bits are dropped.
  logic unused_low_bits;
  assign unused_low_bits = ^{bus.pcPlus4[1:0], bus.branchTarget[1:0]};

  assign bus.pcOut     = pc_q;
  assign bus.imemReq   = req;
  assign bus.ifidValid = slot_valid;
  assign bus.ifidPC    = slot_pc;
  assign bus.ifidInstr = slot_instr;
  assign dbg_state     = state;

endmodule
